// File: rtl/card_pkg.sv
// Shared types and helpers for the baccarat card datapath.
// rank_t holds one card rank: 0 = empty, 1 = ace, 11..13 = J/Q/K.
// card_value maps a rank to its baccarat value (0..9).
// score_mod10 reduces the sum of three card values modulo 10.
package card_pkg;

  typedef logic [3:0] rank_t;

  localparam rank_t RANK_EMPTY = 4'd0;
  localparam rank_t RANK_ACE   = 4'd1;
  localparam rank_t RANK_KING  = 4'd13;

  // Ranks 1..9 count face value; tens, courts and empty slots count zero.
  function automatic logic [3:0] card_value(input rank_t rank);
    return (rank <= 4'd9) ? rank : 4'd0;
  endfunction

  // Maximum sum is 27, so at most one subtraction of 10 or 20 is needed.
  function automatic logic [3:0] score_mod10(input logic [3:0] a, input logic [3:0] b,
                                             input logic [3:0] c);
    logic [4:0] sum;
    sum = {1'b0, a} + {1'b0, b} + {1'b0, c};
    if (sum >= 5'd20) begin
      sum = sum - 5'd20;
    end else if (sum >= 5'd10) begin
      sum = sum - 5'd10;
    end
    return sum[3:0];
  endfunction

endpackage

// File: rtl/card_shoe.sv
// Finite card shoe: LFSR-driven candidate rank, per-rank copy counts and the
// total of cards remaining.
// Ports:
//   i_clk, i_rst        clock and synchronous active-high reset
//   i_draw              consume o_selected_rank this cycle
//   i_reshuffle         restore every rank to full (takes priority over i_draw)
//   i_force_en          use i_force_rank as the candidate instead of the LFSR
//   i_force_rank        forced candidate; 0 or >13 is treated as an ace
//   o_selected_rank     first rank at or above the candidate (wrapping) with copies left
//   o_cards_left        cards remaining in the shoe
module card_shoe
  import card_pkg::*;
#(
  parameter int unsigned DECKS = 1,
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int unsigned CL_W  = $clog2(52 * DECKS + 1)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_draw,
  input  logic            i_reshuffle,
  input  logic            i_force_en,
  input  rank_t           i_force_rank,
  output rank_t           o_selected_rank,
  output logic [CL_W-1:0] o_cards_left
);

  localparam int unsigned CNT_W = $clog2(4 * DECKS + 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(4 * DECKS);
  localparam logic [CL_W-1:0]  FULL_SHOE = CL_W'(52 * DECKS);

  logic [15:0]      r_lfsr;
  logic [CNT_W-1:0] r_cnt [1:13];
  logic [CL_W-1:0]  r_cards_left;

  logic  w_fb;
  rank_t w_cand;
  rank_t w_sel;
  logic  w_found;
  logic [4:0] w_probe;

  // Fibonacci taps 16,14,13,11.
  assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  always_comb begin
    if (i_force_en) begin
      w_cand = (i_force_rank == RANK_EMPTY || i_force_rank > RANK_KING) ? RANK_ACE
                                                                        : i_force_rank;
    end else begin
      w_cand = rank_t'(r_lfsr[7:0] % 8'd13) + 4'd1;
    end
  end

  // Probe candidate, candidate+1, ... wrapping 13 -> 1; take the first nonempty rank.
  always_comb begin
    w_sel   = w_cand;
    w_found = 1'b0;
    w_probe = 5'd0;
    for (int k = 0; k < 13; k++) begin
      w_probe = {1'b0, w_cand} + 5'(k);
      if (w_probe > 5'd13) begin
        w_probe = w_probe - 5'd13;
      end
      if (!w_found && r_cnt[w_probe[3:0]] != '0) begin
        w_sel   = w_probe[3:0];
        w_found = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lfsr <= SEED;
      for (int k = 1; k <= 13; k++) begin
        r_cnt[k] <= FULL_CNT;
      end
      r_cards_left <= FULL_SHOE;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_fb};
      if (i_reshuffle) begin
        for (int k = 1; k <= 13; k++) begin
          r_cnt[k] <= FULL_CNT;
        end
        r_cards_left <= FULL_SHOE;
      end else if (i_draw) begin
        r_cnt[w_sel] <= r_cnt[w_sel] - CNT_W'(1);
        r_cards_left <= r_cards_left - CL_W'(1);
      end
    end
  end

  assign o_selected_rank = w_sel;
  assign o_cards_left    = r_cards_left;

endmodule

// File: rtl/card_shoe_datapath.sv
// Baccarat dealing datapath: answers the controller's one-hot load strobes by
// drawing cards from a finite shoe into six hand registers and reports scores.
// Ports:
//   slow_clock, resetb           clock and synchronous active-high reset
//   load_pcard1..load_dcard3     load strobes, exactly one expected per deal
//   new_hand                     clears the hand; reshuffles if the shoe is low
//   force_en, force_rank         test override of the candidate rank
//   pcard*_out, dcard*_out       hand registers (0 = empty)
//   pscore, dscore               hand totals modulo 10
//   pcard3                       baccarat value of the player's third card
//   cards_left                   cards remaining in the shoe
//   protocol_err                 sticky flag for malformed or illegal loads
module card_shoe_datapath
  import card_pkg::*;
#(
  parameter int unsigned DECKS     = 1,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int unsigned MIN_CARDS = 6,
  localparam int unsigned CL_W     = $clog2(52 * DECKS + 1)
) (
  input  logic            slow_clock,
  input  logic            resetb,
  input  logic            load_pcard1,
  input  logic            load_pcard2,
  input  logic            load_pcard3,
  input  logic            load_dcard1,
  input  logic            load_dcard2,
  input  logic            load_dcard3,
  input  logic            new_hand,
  input  logic            force_en,
  input  logic [3:0]      force_rank,
  output logic [3:0]      pcard1_out,
  output logic [3:0]      pcard2_out,
  output logic [3:0]      pcard3_out,
  output logic [3:0]      dcard1_out,
  output logic [3:0]      dcard2_out,
  output logic [3:0]      dcard3_out,
  output logic [3:0]      pscore,
  output logic [3:0]      dscore,
  output logic [3:0]      pcard3,
  output logic [CL_W-1:0] cards_left,
  output logic            protocol_err
);

  rank_t r_card [6];  // p1, p2, p3, d1, d2, d3
  logic  r_err;

  logic [5:0]      w_loads;
  logic            w_any;
  logic            w_multi;
  rank_t           w_target;
  rank_t           w_sel;
  logic            w_draw;
  logic            w_err;
  logic            w_reshuffle;
  logic [CL_W-1:0] w_cards_left;

  assign w_loads = {load_dcard3, load_dcard2, load_dcard1, load_pcard3, load_pcard2, load_pcard1};
  assign w_any   = |w_loads;
  // More than one bit set iff clearing the lowest set bit leaves something.
  assign w_multi = (w_loads & (w_loads - 6'd1)) != 6'd0;

  always_comb begin
    w_target = RANK_EMPTY;
    for (int k = 0; k < 6; k++) begin
      if (w_loads[k]) begin
        w_target = w_target | r_card[k];
      end
    end
  end

  // new_hand suppresses a coincident load entirely, including its error.
  assign w_err  = !new_hand && w_any &&
                  (w_multi || w_target != RANK_EMPTY || w_cards_left == '0);
  assign w_draw = !new_hand && w_any && !w_err;
  assign w_reshuffle = new_hand && (32'(w_cards_left) < MIN_CARDS);

  card_shoe #(
    .DECKS (DECKS),
    .SEED  (SEED),
    .CL_W  (CL_W)
  ) u_shoe (
    .i_clk           (slow_clock),
    .i_rst           (resetb),
    .i_draw          (w_draw),
    .i_reshuffle     (w_reshuffle),
    .i_force_en      (force_en),
    .i_force_rank    (force_rank),
    .o_selected_rank (w_sel),
    .o_cards_left    (w_cards_left)
  );

  always_ff @(posedge slow_clock) begin
    if (resetb) begin
      for (int k = 0; k < 6; k++) begin
        r_card[k] <= RANK_EMPTY;
      end
      r_err <= 1'b0;
    end else begin
      for (int k = 0; k < 6; k++) begin
        if (new_hand) begin
          r_card[k] <= RANK_EMPTY;
        end else if (w_draw && w_loads[k]) begin
          r_card[k] <= w_sel;
        end
      end
      if (w_err) begin
        r_err <= 1'b1;
      end
    end
  end

  assign pcard1_out   = r_card[0];
  assign pcard2_out   = r_card[1];
  assign pcard3_out   = r_card[2];
  assign dcard1_out   = r_card[3];
  assign dcard2_out   = r_card[4];
  assign dcard3_out   = r_card[5];
  assign pscore       = score_mod10(card_value(r_card[0]), card_value(r_card[1]),
                                    card_value(r_card[2]));
  assign dscore       = score_mod10(card_value(r_card[3]), card_value(r_card[4]),
                                    card_value(r_card[5]));
  assign pcard3       = card_value(r_card[2]);
  assign cards_left   = w_cards_left;
  assign protocol_err = r_err;

endmodule

// File: tb/tb_card_shoe_datapath.sv
module tb_card_shoe_datapath;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetb = 1'b1;
  logic       lp1 = 0, lp2 = 0, lp3 = 0, ld1 = 0, ld2 = 0, ld3 = 0;
  logic       new_hand = 0, force_en = 0;
  logic [3:0] force_rank = 4'd0;
  logic [3:0] p1_o, p2_o, p3_o, d1_o, d2_o, d3_o, pscore, dscore, pcard3;
  logic [5:0] cards_left;
  logic       protocol_err;

  card_shoe_datapath dut (
    .slow_clock   (clk),
    .resetb       (resetb),
    .load_pcard1  (lp1),
    .load_pcard2  (lp2),
    .load_pcard3  (lp3),
    .load_dcard1  (ld1),
    .load_dcard2  (ld2),
    .load_dcard3  (ld3),
    .new_hand     (new_hand),
    .force_en     (force_en),
    .force_rank   (force_rank),
    .pcard1_out   (p1_o),
    .pcard2_out   (p2_o),
    .pcard3_out   (p3_o),
    .dcard1_out   (d1_o),
    .dcard2_out   (d2_o),
    .dcard3_out   (d3_o),
    .pscore       (pscore),
    .dscore       (dscore),
    .pcard3       (pcard3),
    .cards_left   (cards_left),
    .protocol_err (protocol_err)
  );

  int total = 0;
  int bad   = 0;

  // Reference shoe: plain counts per rank, hand as an array of ranks.
  int          m_card [6];
  int          m_cnt  [14];
  int          m_left;
  int          m_err;
  logic [15:0] m_lfsr;

  function automatic int mval(input int r);
    return (r >= 1 && r <= 9) ? r : 0;
  endfunction

  function automatic int mscore(input int a, input int b, input int c);
    return (mval(a) + mval(b) + mval(c)) % 10;
  endfunction

  // Apply the rules for the edge about to happen, using the driven inputs.
  task automatic model_step();
    logic [5:0] ld;
    int n, idx, r;
    ld = {ld3, ld2, ld1, lp3, lp2, lp1};
    if (resetb) begin
      foreach (m_card[k]) m_card[k] = 0;
      for (int k = 1; k <= 13; k++) m_cnt[k] = 4;
      m_left = 52;
      m_err  = 0;
      m_lfsr = 16'hACE1;
      return;
    end
    n   = $countones(ld);
    idx = 0;
    if (new_hand) begin
      foreach (m_card[k]) m_card[k] = 0;
      if (m_left < 6) begin
        for (int k = 1; k <= 13; k++) m_cnt[k] = 4;
        m_left = 52;
      end
    end else if (n > 1) begin
      m_err = 1;
    end else if (n == 1) begin
      for (int k = 0; k < 6; k++) if (ld[k]) idx = k;
      if (m_card[idx] != 0 || m_left == 0) begin
        m_err = 1;
      end else begin
        if (force_en) r = (force_rank >= 1 && force_rank <= 13) ? int'(force_rank) : 1;
        else r = int'(m_lfsr[7:0]) % 13 + 1;
        for (int t = 0; t < 13 && m_cnt[r] == 0; t++) r = (r == 13) ? 1 : r + 1;
        m_card[idx] = r;
        m_cnt[r]    = m_cnt[r] - 1;
        m_left      = m_left - 1;
      end
    end
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  endtask

  task automatic step(input int ld, input int nh, input int fe, input int fr, input int rst);
    {ld3, ld2, ld1, lp3, lp2, lp1} = 6'(ld);
    new_hand   = (nh != 0);
    force_en   = (fe != 0);
    force_rank = 4'(fr);
    resetb     = (rst != 0);
    model_step();
    @(posedge clk);
    #1;
    {ld3, ld2, ld1, lp3, lp2, lp1} = 6'd0;
    new_hand = 1'b0;
    resetb   = 1'b0;
  endtask

  task automatic deal(input int slot, input int fe, input int fr);
    step(1 << slot, 0, fe, fr, 0);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    total++;
    if (act !== 32'(exp)) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int e1, input int e2, input int e3,
                           input int f1, input int f2, input int f3, input int eps,
                           input int eds, input int epc3, input int eleft, input int eerr);
    chk({tag, " pcard1"}, 32'(p1_o), e1);
    chk({tag, " pcard2"}, 32'(p2_o), e2);
    chk({tag, " pcard3_out"}, 32'(p3_o), e3);
    chk({tag, " dcard1"}, 32'(d1_o), f1);
    chk({tag, " dcard2"}, 32'(d2_o), f2);
    chk({tag, " dcard3"}, 32'(d3_o), f3);
    chk({tag, " pscore"}, 32'(pscore), eps);
    chk({tag, " dscore"}, 32'(dscore), eds);
    chk({tag, " pcard3"}, 32'(pcard3), epc3);
    chk({tag, " cards_left"}, 32'(cards_left), eleft);
    chk({tag, " protocol_err"}, 32'(protocol_err), eerr);
  endtask

  typedef struct {
    string nm;
    int ld, nh, fe, fr, rst;
    int p1, p2, p3, d1, d2, d3, ps, ds, pc3, left, err;
  } vec_t;

  vec_t vt [22];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    //          name        ld nh fe fr rst  p1 p2 p3 d1 d2 d3 ps ds pc3 left err
    vt[0]  = '{"reset",     0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0, 0, 0, 52, 0};
    vt[1]  = '{"idle",      0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 52, 0};
    vt[2]  = '{"p1=9",      1, 0, 1, 9, 0,   9, 0, 0, 0, 0, 0, 9, 0, 0, 51, 0};
    vt[3]  = '{"p2=K",      2, 0, 1, 13, 0,  9, 13, 0, 0, 0, 0, 9, 0, 0, 50, 0};
    vt[4]  = '{"nh1",       0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 50, 0};
    vt[5]  = '{"p1=7",      1, 0, 1, 7, 0,   7, 0, 0, 0, 0, 0, 7, 0, 0, 49, 0};
    vt[6]  = '{"p2=8",      2, 0, 1, 8, 0,   7, 8, 0, 0, 0, 0, 5, 0, 0, 48, 0};
    vt[7]  = '{"p3=6",      4, 0, 1, 6, 0,   7, 8, 6, 0, 0, 0, 1, 0, 6, 47, 0};
    vt[8]  = '{"d1=K",      8, 0, 1, 13, 0,  7, 8, 6, 13, 0, 0, 1, 0, 6, 46, 0};
    vt[9]  = '{"d2=10",     16, 0, 1, 10, 0, 7, 8, 6, 13, 10, 0, 1, 0, 6, 45, 0};
    vt[10] = '{"d3=f0",     32, 0, 1, 0, 0,  7, 8, 6, 13, 10, 1, 1, 1, 6, 44, 0};
    vt[11] = '{"multi",     9, 0, 1, 2, 0,   7, 8, 6, 13, 10, 1, 1, 1, 6, 44, 1};
    vt[12] = '{"reload",    1, 0, 1, 2, 0,   7, 8, 6, 13, 10, 1, 1, 1, 6, 44, 1};
    vt[13] = '{"midreset",  0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0, 0, 0, 52, 0};
    vt[14] = '{"nh+load",   1, 1, 1, 3, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 52, 0};
    vt[15] = '{"idle2",     0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 52, 0};
    vt[16] = '{"d1=f15",    8, 0, 1, 15, 0,  0, 0, 0, 1, 0, 0, 0, 1, 0, 51, 0};
    vt[17] = '{"nh2",       0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 51, 0};
    vt[18] = '{"p1=9b",     1, 0, 1, 9, 0,   9, 0, 0, 0, 0, 0, 9, 0, 0, 50, 0};
    vt[19] = '{"p2=9b",     2, 0, 1, 9, 0,   9, 9, 0, 0, 0, 0, 8, 0, 0, 49, 0};
    vt[20] = '{"p3=9b",     4, 0, 1, 9, 0,   9, 9, 9, 0, 0, 0, 7, 0, 9, 48, 0};
    vt[21] = '{"nh3",       0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 48, 0};

    for (int i = 0; i < 22; i++) begin
      step(vt[i].ld, vt[i].nh, vt[i].fe, vt[i].fr, vt[i].rst);
      check_all(vt[i].nm, vt[i].p1, vt[i].p2, vt[i].p3, vt[i].d1, vt[i].d2, vt[i].d3,
                vt[i].ps, vt[i].ds, vt[i].pc3, vt[i].left, vt[i].err);
    end

    // Rank exhaustion: four fives leave none, later fives become sixes.
    step(0, 0, 0, 0, 1);
    for (int k = 0; k < 4; k++) deal(k, 1, 5);
    chk("five p1", 32'(p1_o), 5);
    chk("five d1", 32'(d1_o), 5);
    deal(4, 1, 5);
    chk("five exhausted d2", 32'(d2_o), 6);
    deal(5, 1, 5);
    chk("five still empty d3", 32'(d3_o), 6);
    chk("exhaust cards_left", 32'(cards_left), 46);
    step(0, 1, 0, 0, 0);
    for (int k = 0; k < 4; k++) deal(k, 1, 13);
    chk("king p3", 32'(p3_o), 13);
    deal(4, 1, 13);
    chk("king wraps to ace", 32'(d2_o), 1);
    chk("wrap dscore", 32'(dscore), 1);
    chk("wrap protocol_err", 32'(protocol_err), 0);

    // Reshuffle threshold: new_hand at 6 keeps the shoe, at 5 refills it.
    step(0, 0, 0, 0, 1);
    for (int h = 0; h < 7; h++) begin
      for (int k = 0; k < 6; k++) deal(k, 0, 0);
      step(0, 1, 0, 0, 0);
    end
    chk("seven hands cards_left", 32'(cards_left), 10);
    for (int k = 0; k < 4; k++) deal(k, 0, 0);
    chk("pre nh6 cards_left", 32'(cards_left), 6);
    step(0, 1, 0, 0, 0);
    chk("nh at 6 cards_left", 32'(cards_left), 6);
    chk("nh at 6 pcard1", 32'(p1_o), 0);
    deal(0, 0, 0);
    chk("pre nh5 cards_left", 32'(cards_left), 5);
    step(0, 1, 0, 0, 0);
    chk("nh at 5 cards_left", 32'(cards_left), 52);
    chk("nh at 5 pcard1", 32'(p1_o), 0);
    chk("reshuffle protocol_err", 32'(protocol_err), 0);

    // Random traffic against the reference shoe.
    for (int i = 0; i < 3000; i++) begin
      int r, sel, ld;
      r   = int'($urandom_range(0, 99));
      sel = int'($urandom_range(0, 9));
      if (sel < 6) ld = 1 << sel;
      else if (sel < 8) ld = (1 << $urandom_range(0, 5)) | (1 << $urandom_range(0, 5));
      else ld = 0;
      step(ld, (r >= 1 && r <= 8) ? 1 : 0, int'($urandom_range(0, 1)),
           int'($urandom_range(0, 15)), (r == 0) ? 1 : 0);
      check_all("rand", m_card[0], m_card[1], m_card[2], m_card[3], m_card[4], m_card[5],
                mscore(m_card[0], m_card[1], m_card[2]),
                mscore(m_card[3], m_card[4], m_card[5]),
                mval(m_card[2]), m_left, m_err);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
